// File: rtl/uart_block_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// uart_block_sequencer_pkg
// Shared definitions for the UART-to-cipher block sequencer:
//   - FSM state encoding (FILL, START, RUN, PEND), 2 bits
//   - default bytes per cipher block and the resulting block width
// -----------------------------------------------------------------------------
package uart_block_sequencer_pkg;

    localparam int DEF_BLOCK_BYTES = 16;
    localparam int DEF_BLOCK_W     = 8 * DEF_BLOCK_BYTES;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,   // cipher idle, assembling a block
        ST_START = 2'd1,   // launch pulse cycle
        ST_RUN   = 2'd2,   // cipher busy, assembling the next block
        ST_PEND  = 2'd3    // cipher busy, next block complete and held
    } seq_state_e;

endpackage

// File: rtl/uart_block_sequencer_rx_idle_timer.sv
// -----------------------------------------------------------------------------
// rx_idle_timer
// Counts idle clocks since the last received byte. Raises a one-cycle
// combinational `expired` on the clock in which the count would reach
// TIMEOUT_CYCLES, and restarts from zero at that edge.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   kick     in   restart the count (byte accepted or assembly cleared)
//   enable   in   a partial block is held and may time out
//   expired  out  timeout reached this cycle
// -----------------------------------------------------------------------------
module rx_idle_timer
    import uart_block_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TO_W           = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] idle_q;
    logic [TO_W-1:0] idle_d;

    // A kick in the same cycle as the final idle clock wins over expiry.
    assign expired = enable && !kick && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Held at zero while no partial block exists, so a fresh block always
    // starts counting from its first byte.
    always_comb begin
        idle_d = idle_q + TO_W'(1);
        if (kick || !enable || expired) begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/uart_block_sequencer.sv
// -----------------------------------------------------------------------------
// uart_block_sequencer
// Packs UART bytes into cipher blocks (first byte in the MSBs), launches the
// cipher with a one-cycle start pulse and double-buffers the next block while
// the cipher runs. Stale partial blocks are discarded after an idle timeout;
// bytes arriving while a full block is already waiting are dropped and
// flagged.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   rxd_done      in   one-cycle strobe, rxd_byte valid
//   rxd_byte      in   received byte
//   clr           in   discard the partial assembly
//   cipher_done   in   one-cycle strobe, cipher finished
//   block_out     out  block presented to the cipher
//   cipher_start  out  one-cycle launch pulse
//   byte_count    out  bytes held in the assembly register
//   overrun       out  one-cycle pulse, byte dropped
//   timeout       out  one-cycle pulse, partial block discarded
// -----------------------------------------------------------------------------
module uart_block_sequencer
    import uart_block_sequencer_pkg::*;
#(
    parameter int  BLOCK_BYTES    = DEF_BLOCK_BYTES,
    parameter int  TIMEOUT_CYCLES = 2_000_000,
    parameter int  TO_W           = 24,
    localparam int BLK_W          = 8 * BLOCK_BYTES,
    localparam int CNT_W          = $clog2(BLOCK_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd_done,
    input  logic [7:0]       rxd_byte,
    input  logic             clr,
    input  logic             cipher_done,
    output logic [BLK_W-1:0] block_out,
    output logic             cipher_start,
    output logic [CNT_W-1:0] byte_count,
    output logic             overrun,
    output logic             timeout
);

    seq_state_e       state_q, state_d;
    logic [BLK_W-1:0] asm_q, asm_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             ovr_q, ovr_d;
    logic             to_q, to_d;

    logic             expired;
    logic             kick;
    logic             tmr_en;
    logic             last_byte;
    logic             full_in;
    logic [BLK_W-1:0] shifted;

    assign shifted   = {asm_q[BLK_W-9:0], rxd_byte};
    assign last_byte = (cnt_q == CNT_W'(BLOCK_BYTES - 1));
    // Completing byte accepted this cycle (never true in PEND's drop path).
    assign full_in   = rxd_done && !clr && last_byte;

    // Bytes are accepted everywhere except PEND; clr also restarts the timer.
    assign kick   = clr || (rxd_done && (state_q != ST_PEND));
    assign tmr_en = ((state_q == ST_FILL) || (state_q == ST_RUN)) && (cnt_q != '0);

    rx_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .kick    (kick),
        .enable  (tmr_en),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        ovr_d   = 1'b0;
        to_d    = 1'b0;

        if (state_q == ST_PEND) begin
            ovr_d = rxd_done && !clr;
            if (clr) begin
                // Held block discarded; if the cipher finishes in the same
                // cycle there is nothing left to wait for.
                asm_d   = '0;
                cnt_d   = '0;
                state_d = cipher_done ? ST_FILL : ST_RUN;
            end else if (cipher_done) begin
                blk_d   = asm_q;
                asm_d   = '0;
                cnt_d   = '0;
                state_d = ST_START;
            end
        end else begin
            // Assembly datapath shared by FILL, START and RUN.
            if (clr) begin
                asm_d = '0;
                cnt_d = '0;
            end else if (rxd_done) begin
                if (last_byte && ((state_q == ST_FILL) ||
                                  ((state_q == ST_RUN) && cipher_done))) begin
                    blk_d = shifted;
                    asm_d = '0;
                    cnt_d = '0;
                end else if (last_byte) begin
                    asm_d = shifted;
                    cnt_d = CNT_W'(BLOCK_BYTES);
                end else begin
                    asm_d = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (expired) begin
                asm_d = '0;
                cnt_d = '0;
                to_d  = 1'b1;
            end

            // Control: cipher_done is only honoured in RUN.
            if (state_q == ST_FILL) begin
                if (full_in) state_d = ST_START;
            end else if (state_q == ST_START) begin
                state_d = full_in ? ST_PEND : ST_RUN;
            end else begin
                if (full_in)          state_d = cipher_done ? ST_START : ST_PEND;
                else if (cipher_done) state_d = ST_FILL;
            end
        end

        start_d = (state_d == ST_START);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
            asm_q   <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    assign block_out    = blk_q;
    assign cipher_start = start_q;
    assign byte_count   = cnt_q;
    assign overrun      = ovr_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_uart_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_block_sequencer
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level model built from a byte queue and a cipher
// busy flag.
// -----------------------------------------------------------------------------
module tb_uart_block_sequencer;

    localparam int T = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rxd_done = 1'b0;
    logic [7:0]   rxd_byte = 8'h00;
    logic         clr = 1'b0;
    logic         cipher_done = 1'b0;
    logic [127:0] block_out;
    logic         cipher_start;
    logic [4:0]   byte_count;
    logic         overrun;
    logic         timeout;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0]   mq[$];
    bit           m_busy, m_start, m_ovr, m_to;
    int           m_idle;
    logic [127:0] m_blk;

    always #5 clk = ~clk;

    uart_block_sequencer #(
        .BLOCK_BYTES    (16),
        .TIMEOUT_CYCLES (T),
        .TO_W           (24)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd_done     (rxd_done),
        .rxd_byte     (rxd_byte),
        .clr          (clr),
        .cipher_done  (cipher_done),
        .block_out    (block_out),
        .cipher_start (cipher_start),
        .byte_count   (byte_count),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    function automatic logic [127:0] pack_q();
        logic [127:0] r = '0;
        foreach (mq[i]) r = {r[119:0], mq[i]};
        return r;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_busy = 0; m_start = 0; m_ovr = 0; m_to = 0; m_idle = 0; m_blk = '0;
    endfunction

    // One clock of the reference: inputs sampled at the edge.
    function automatic void model_step(bit rd, logic [7:0] b, bit c, bit d);
        bit nstart = 0, novr = 0, nto = 0;
        bit eff_done = m_busy && !m_start && d;
        if (mq.size() == 16) begin
            if (rd && !c) novr = 1;
            if (c) begin
                mq.delete(); m_idle = 0;
                if (eff_done) m_busy = 0;
            end else if (eff_done) begin
                m_blk = pack_q(); mq.delete(); nstart = 1;
            end
        end else if (c) begin
            mq.delete(); m_idle = 0;
            if (eff_done) m_busy = 0;
        end else if (rd) begin
            mq.push_back(b); m_idle = 0;
            if (mq.size() == 16) begin
                if (!m_busy || eff_done) begin
                    m_blk = pack_q(); mq.delete(); nstart = 1; m_busy = 1;
                end
            end else if (eff_done) begin
                m_busy = 0;
            end
        end else begin
            if (eff_done) m_busy = 0;
            if (!m_start && mq.size() > 0) begin
                m_idle++;
                if (m_idle == T) begin
                    mq.delete(); m_idle = 0; nto = 1;
                end
            end
        end
        m_start = nstart; m_ovr = novr; m_to = nto;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".block_out"}, block_out, m_blk);
        chk({tag, ".byte_count"}, 128'(byte_count), 128'(mq.size()));
        chk({tag, ".cipher_start"}, 128'(cipher_start), 128'(m_start));
        chk({tag, ".overrun"}, 128'(overrun), 128'(m_ovr));
        chk({tag, ".timeout"}, 128'(timeout), 128'(m_to));
    endtask

    task automatic step(input string tag, input bit rd, input logic [7:0] b,
                        input bit c, input bit d);
        rxd_done = rd; rxd_byte = b; clr = c; cipher_done = d;
        @(posedge clk);
        model_step(rd, b, c, d);
        #1;
        chk_all(tag);
        rxd_done = 0; clr = 0; cipher_done = 0;
    endtask

    task automatic send(input string tag, input int first, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 8'(first + i), 1'b0, 1'b0);
    endtask

    initial begin
        int to_seen;
        int pct;
        model_reset();

        // Reset state
        #12;
        chk_all("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Block 0x00..0x0F launched from FILL
        send("t1", 8'h00, 16);
        chk("t1.block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
        chk("t1.start", 128'(cipher_start), 128'd1);
        step("t1.idle", 0, 8'h00, 0, 0);
        chk("t1.start_drop", 128'(cipher_start), 128'd0);

        // Full block held while cipher busy, overrun, release
        send("t2", 8'h10, 16);
        chk("t2.pend_count", 128'(byte_count), 128'd16);
        step("t2.ovr", 1, 8'hAA, 0, 0);
        chk("t2.overrun", 128'(overrun), 128'd1);
        step("t2.release", 0, 8'h00, 0, 1);
        chk("t2.block", block_out, 128'h101112131415161718191A1B1C1D1E1F);
        chk("t2.start", 128'(cipher_start), 128'd1);
        step("t2.run", 0, 8'h00, 0, 0);
        step("t2.done", 0, 8'h00, 0, 1);

        // Idle timeout of a partial block
        send("t3", 8'h50, 5);
        to_seen = 0;
        for (int i = 0; i < T + 5; i++) begin
            step("t3.idle", 0, 8'h00, 0, 0);
            if (timeout) to_seen++;
        end
        chk("t3.to_pulses", 128'(to_seen), 128'd1);
        chk("t3.count", 128'(byte_count), 128'd0);
        send("t3b", 8'h20, 16);
        chk("t3.block", block_out, 128'h202122232425262728292A2B2C2D2E2F);

        // 16th byte and cipher_done in the same RUN cycle
        step("t4.start", 0, 8'h00, 0, 0);
        send("t4", 8'h60, 15);
        step("t4.both", 1, 8'h6F, 0, 1);
        chk("t4.block", block_out, 128'h606162636465666768696A6B6C6D6E6F);
        chk("t4.start", 128'(cipher_start), 128'd1);
        step("t4.run", 0, 8'h00, 0, 0);
        step("t4.done", 0, 8'h00, 0, 1);

        // Asynchronous reset mid-assembly
        send("t5", 8'h70, 7);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk_all("t5.async");
        @(posedge clk); #1;
        rst = 1'b1;
        send("t5b", 8'hF0, 16);
        chk("t5.block", block_out, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        step("t5.run", 0, 8'h00, 0, 0);
        step("t5.done", 0, 8'h00, 0, 1);

        // clr discards a partial block
        send("t6", 8'h40, 9);
        step("t6.clr", 1, 8'h99, 1, 0);
        chk("t6.count", 128'(byte_count), 128'd0);
        chk("t6.ovr", 128'(overrun), 128'd0);
        send("t6b", 8'h30, 16);
        chk("t6.block", block_out, 128'h303132333435363738393A3B3C3D3E3F);

        // Randomized traffic in phases of different byte density
        for (int ph = 0; ph < 8; ph++) begin
            pct = (ph % 4 == 0) ? 1 : (ph % 4 == 1) ? 40 : (ph % 4 == 2) ? 90 : 5;
            for (int i = 0; i < 400; i++) begin
                step("rand",
                     $urandom_range(0, 99) < pct,
                     8'($urandom),
                     $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 8);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
